// File: rtl/sd_write.sv
// SPI-mode SD single-block write engine: CMD24, 512-byte payload, data-response
// token check and busy wait, driving the card pins through a byte-level mode-0 shifter.
module sd_write #(
    parameter int CLK_DIV      = 4,
    parameter int BLOCK_BYTES  = 512,
    parameter int R1_TIMEOUT   = 8,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [7:0]  wr_data,
    output logic        wr_data_req,
    output logic [8:0]  byte_idx,
    output logic        done,
    output logic        error,
    output logic [4:0]  resp_token,
    output logic        sclk,
    output logic        cs,
    output logic        mosi,
    input  logic        miso
);
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA,
        S_CRC, S_DRESP, S_BUSY, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] DATA_LAST = 16'(BLOCK_BYTES - 1);
    localparam logic [15:0] R1_LAST   = 16'(R1_TIMEOUT - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);

    state_t      state_r, state_n;
    logic [15:0] cnt_r, cnt_n, div_r, div_n;
    logic [31:0] addr_r, addr_n;
    logic [7:0]  tx_r, tx_n, rx_r, rx_n, load_byte_s;
    logic [3:0]  half_r, half_n;
    logic        shift_r, shift_n, sclk_r, sclk_n, mosi_r, mosi_n;
    logic        cs_r, cs_n, done_r, done_n, error_r, error_n, req_r, req_n;
    logic [4:0]  resp_r, resp_n;
    logic [8:0]  byte_idx_r, idx_n;
    logic        load_s, stop_s, byte_end_s, end_n_s;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] a);
        case (idx)
            3'd0:    cmd_byte = 8'h58;
            3'd1:    cmd_byte = a[31:24];
            3'd2:    cmd_byte = a[23:16];
            3'd3:    cmd_byte = a[15:8];
            3'd4:    cmd_byte = a[7:0];
            default: cmd_byte = 8'hFF;
        endcase
    endfunction

    // last clk of a byte: the next edge produces its final sclk fall
    assign byte_end_s = shift_r && (div_r == DIV_LAST) && (half_r == 4'd15);

    // next-state, byte sequencing and shifter timing
    always_comb begin
        state_n = state_r;  cnt_n  = cnt_r;   addr_n  = addr_r;   tx_n   = tx_r;
        rx_n    = rx_r;     div_n  = div_r;   half_n  = half_r;   shift_n = shift_r;
        sclk_n  = sclk_r;   mosi_n = mosi_r;  cs_n    = cs_r;     done_n = done_r;
        error_n = error_r;  resp_n = resp_r;
        load_s  = 1'b0;     stop_s = 1'b0;    load_byte_s = 8'hFF;
        if (req_r) begin
            idx_n = byte_idx_r + 9'd1;
        end else begin
            idx_n = byte_idx_r;
        end

        case (state_r)
            S_IDLE: begin
                done_n  = 1'b0;
                error_n = 1'b0;
                if (start) begin
                    addr_n      = addr;
                    cnt_n       = 16'd0;
                    cs_n        = 1'b0;
                    load_s      = 1'b1;
                    load_byte_s = 8'h58;
                    state_n     = S_CMD;
                end else begin
                    cs_n = 1'b1;
                end
            end
            S_CMD: begin
                if (byte_end_s) begin
                    load_s = 1'b1;
                    if (cnt_r == 16'd5) begin
                        cnt_n   = 16'd0;
                        state_n = S_R1;
                    end else begin
                        cnt_n       = cnt_r + 16'd1;
                        load_byte_s = cmd_byte(cnt_r[2:0] + 3'd1, addr_r);
                    end
                end else begin
                    state_n = S_CMD;
                end
            end
            S_R1: begin
                if (byte_end_s) begin
                    if (!rx_r[7]) begin
                        if (rx_r == 8'h00) begin
                            state_n = S_GAP;
                            load_s  = 1'b1;
                        end else begin
                            state_n = S_ERR;
                            stop_s  = 1'b1;
                        end
                    end else if (cnt_r == R1_LAST) begin
                        state_n = S_ERR;
                        stop_s  = 1'b1;
                    end else begin
                        cnt_n  = cnt_r + 16'd1;
                        load_s = 1'b1;
                    end
                end else begin
                    state_n = S_R1;
                end
            end
            S_GAP: begin
                if (byte_end_s) begin
                    state_n     = S_TOKEN;
                    load_s      = 1'b1;
                    load_byte_s = 8'hFE;
                end else begin
                    state_n = S_GAP;
                end
            end
            S_TOKEN: begin
                if (byte_end_s) begin
                    state_n     = S_DATA;
                    cnt_n       = 16'd0;
                    load_s      = 1'b1;
                    load_byte_s = wr_data;
                end else begin
                    state_n = S_TOKEN;
                end
            end
            S_DATA: begin
                if (byte_end_s) begin
                    load_s = 1'b1;
                    if (cnt_r == DATA_LAST) begin
                        cnt_n   = 16'd0;
                        state_n = S_CRC;
                    end else begin
                        cnt_n       = cnt_r + 16'd1;
                        load_byte_s = wr_data;
                    end
                end else begin
                    state_n = S_DATA;
                end
            end
            S_CRC: begin
                if (byte_end_s) begin
                    load_s = 1'b1;
                    if (cnt_r == 16'd1) begin
                        cnt_n   = 16'd0;
                        state_n = S_DRESP;
                    end else begin
                        cnt_n = cnt_r + 16'd1;
                    end
                end else begin
                    state_n = S_CRC;
                end
            end
            S_DRESP: begin
                if (byte_end_s) begin
                    resp_n = rx_r[4:0];
                    if (rx_r[4:0] == 5'b00101) begin
                        cnt_n   = 16'd0;
                        load_s  = 1'b1;
                        state_n = S_BUSY;
                    end else begin
                        stop_s  = 1'b1;
                        state_n = S_ERR;
                    end
                end else begin
                    state_n = S_DRESP;
                end
            end
            S_BUSY: begin
                if (byte_end_s) begin
                    if (rx_r == 8'hFF) begin
                        stop_s  = 1'b1;
                        state_n = S_DONE;
                    end else if (cnt_r == BUSY_LAST) begin
                        stop_s  = 1'b1;
                        state_n = S_ERR;
                    end else begin
                        cnt_n  = cnt_r + 16'd1;
                        load_s = 1'b1;
                    end
                end else begin
                    state_n = S_BUSY;
                end
            end
            S_DONE, S_ERR: begin
                // first cycle raises cs and done; later cycles wait for start to drop
                if (!done_r) begin
                    cs_n    = 1'b1;
                    done_n  = 1'b1;
                    error_n = (state_r == S_ERR);
                end else if (!start) begin
                    state_n = S_IDLE;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    idx_n   = 9'd0;
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = S_IDLE;
                stop_s  = 1'b1;
                cs_n    = 1'b1;
            end
        endcase

        if (load_s) begin
            shift_n = 1'b1;
            div_n   = 16'd0;
            half_n  = 4'd0;
            sclk_n  = 1'b0;
            tx_n    = load_byte_s;
            mosi_n  = load_byte_s[7];
        end else if (stop_s) begin
            shift_n = 1'b0;
            div_n   = 16'd0;
            half_n  = 4'd0;
            sclk_n  = 1'b0;
            mosi_n  = 1'b1;
        end else if (shift_r && (div_r == DIV_LAST)) begin
            div_n  = 16'd0;
            half_n = half_r + 4'd1;
            if (!half_r[0]) begin
                sclk_n = 1'b1;
                rx_n   = {rx_r[6:0], miso};
            end else begin
                sclk_n = 1'b0;
                tx_n   = {tx_r[6:0], 1'b1};
                mosi_n = tx_r[6];
            end
        end else if (shift_r) begin
            div_n = div_r + 16'd1;
        end else begin
            div_n = 16'd0;
        end

        // request lands on the clk whose edge loads the payload byte into tx_r
        end_n_s = shift_n && (div_n == DIV_LAST) && (half_n == 4'd15);
        req_n   = end_n_s && ((state_n == S_TOKEN) ||
                              ((state_n == S_DATA) && (cnt_n != DATA_LAST)));
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= 16'd0;
            addr_r     <= 32'd0;
            tx_r       <= 8'hFF;
            rx_r       <= 8'h00;
            div_r      <= 16'd0;
            half_r     <= 4'd0;
            shift_r    <= 1'b0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b1;
            cs_r       <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            resp_r     <= 5'd0;
            req_r      <= 1'b0;
            byte_idx_r <= 9'd0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            addr_r     <= addr_n;
            tx_r       <= tx_n;
            rx_r       <= rx_n;
            div_r      <= div_n;
            half_r     <= half_n;
            shift_r    <= shift_n;
            sclk_r     <= sclk_n;
            mosi_r     <= mosi_n;
            cs_r       <= cs_n;
            done_r     <= done_n;
            error_r    <= error_n;
            resp_r     <= resp_n;
            req_r      <= req_n;
            byte_idx_r <= idx_n;
        end
    end

    assign wr_data_req = req_r;
    assign byte_idx    = byte_idx_r;
    assign done        = done_r;
    assign error       = error_r;
    assign resp_token  = resp_r;
    assign sclk        = sclk_r;
    assign cs          = cs_r;
    assign mosi        = mosi_r;
endmodule
